// File: rtl/fir_mac_sequencer_if.sv
// Handshake and shared-multiplier bus of the FIR MAC sequencer.
// The slave side is the sequencer; the master side is the sample source, consumer and multiplier.
interface fir_mac_sequencer_if #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12
);
  logic                     IN_VALID;
  logic                     IN_READY;
  logic [DATA_W-1:0]        IN_DATA;
  logic [DATA_W-1:0]        MULT_A;
  logic [2:0]               COEF_IDX;
  logic [DATA_W+COEF_W-1:0] MULT_P;
  logic                     OUT_VALID;
  logic                     OUT_READY;
  logic [DATA_W-1:0]        OUT_DATA;
  logic                     BUSY;
  logic                     OVF;

  modport slave (
    input  IN_VALID, IN_DATA, MULT_P, OUT_READY,
    output IN_READY, MULT_A, COEF_IDX, OUT_VALID, OUT_DATA, BUSY, OVF
  );

  modport master (
    output IN_VALID, IN_DATA, MULT_P, OUT_READY,
    input  IN_READY, MULT_A, COEF_IDX, OUT_VALID, OUT_DATA, BUSY, OVF
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-shares one external multiplier across TAPS filter taps: one MAC per cycle,
// then round-half-up, saturate and hold the result until the consumer takes it.
module fir_mac_sequencer #(
  parameter int DATA_W = 12,
  parameter int COEF_W = 12,
  parameter int TAPS   = 5,
  parameter int FRAC   = 10,
  parameter int ACC_W  = 28
) (
  input  logic              CLK,
  input  logic              RESET_N,
  fir_mac_sequencer_if.slave bus
);
  localparam int PW = DATA_W + COEF_W;
  localparam int KW = $clog2(TAPS);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1) << (FRAC-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) << (DATA_W-1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, ROUND, HOLD} state_t;

  state_t                      state_q, state_d;
  logic [TAPS-1:0][DATA_W-1:0] delay_q, delay_d;
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic [2:0]                  k_q, k_d;
  logic [DATA_W-1:0]           out_q, out_d;
  logic                        vld_q, vld_d;
  logic                        ovf_q, ovf_d;

  logic                        last_tap;
  logic signed [ACC_W-1:0]     prod_ext, rnd_sum, r;

  assign last_tap = (k_q == 3'(TAPS-1));
  assign prod_ext = {{(ACC_W-PW){bus.MULT_P[PW-1]}}, bus.MULT_P};
  assign rnd_sum  = acc_q + RND;
  assign r        = rnd_sum >>> FRAC;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      delay_q <= '0;
      acc_q   <= '0;
      k_q     <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.IN_VALID)  state_d = MAC;
      MAC:     if (last_tap)      state_d = ROUND;
      ROUND:                      state_d = HOLD;
      HOLD:    if (bus.OUT_READY) state_d = IDLE;
      default:                    state_d = IDLE;
    endcase
  end

  // Datapath next-state and bus outputs; multiplier operands are parked at 0 outside MAC.
  always_comb begin
    delay_d      = delay_q;
    acc_d        = acc_q;
    k_d          = k_q;
    out_d        = out_q;
    vld_d        = vld_q;
    ovf_d        = ovf_q;
    bus.IN_READY = (state_q == IDLE);
    bus.BUSY     = (state_q != IDLE);
    bus.MULT_A   = '0;
    bus.COEF_IDX = '0;
    unique case (state_q)
      IDLE: if (bus.IN_VALID) begin
        delay_d = {delay_q[TAPS-2:0], bus.IN_DATA};
        acc_d   = '0;
        k_d     = '0;
      end
      MAC: begin
        bus.MULT_A   = delay_q[k_q[KW-1:0]];
        bus.COEF_IDX = k_q;
        acc_d        = acc_q + prod_ext;
        k_d          = last_tap ? 3'd0 : k_q + 3'd1;
      end
      ROUND: begin
        vld_d = 1'b1;
        if (r > SAT_MAX) begin
          out_d = SAT_MAX[DATA_W-1:0];
          ovf_d = 1'b1;
        end else if (r < SAT_MIN) begin
          out_d = SAT_MIN[DATA_W-1:0];
          ovf_d = 1'b1;
        end else begin
          out_d = r[DATA_W-1:0];
          ovf_d = 1'b0;
        end
      end
      HOLD: if (bus.OUT_READY) vld_d = 1'b0;
      default: ;
    endcase
  end

  always_comb begin
    bus.OUT_VALID = vld_q;
    bus.OUT_DATA  = out_q;
    bus.OVF       = ovf_q;
  end
endmodule
